// File: rtl/fifo_drain_pkg.sv
// fifo_drain shared types: FSM state encoding and skid buffer depth.
package fifo_drain_pkg;

  typedef enum logic {
    ST_RUN,
    ST_FLUSH
  } drain_state_t;

  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/fifo_drain_skid.sv
// Two-entry skid buffer; dout is the head word and holds its last value when empty.
module fifo_drain_skid
  import fifo_drain_pkg::*;
#(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr,
  input  logic             rd,
  input  logic [width-1:0] din,
  output logic [width-1:0] dout,
  output logic [1:0]       count
);

  logic [width-1:0] tail;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else begin
      unique case (1'b1)
        (wr && rd): begin
          if (count == 2'(SKID_DEPTH)) begin
            dout <= tail;
            tail <= din;
          end else begin
            dout <= din;
          end
        end
        (wr && !rd): begin
          if (count == 2'd0) dout <= din;
          else               tail <= din;
          count <= count + 2'd1;
        end
        (rd && !wr): begin
          // shift only when a second word exists so an emptied head keeps its value
          if (count == 2'(SKID_DEPTH)) dout <= tail;
          count <= count - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_drain.sv
// Read-side drain for fifo_flops: pops into a skid buffer, streams out, supports flush.
// Optional statistics counters n_fwd/n_drop are built when FIFO_DRAIN_STATS_EN is defined.
module fifo_drain
  import fifo_drain_pkg::*;
#(
  parameter int width = 16,
  parameter int cnt_w = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] fifo_dout,
  input  logic             fifo_pndng,
  output logic             fifo_pop,
  input  logic             en,
  input  logic             flush,
  output logic [width-1:0] dato_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
`ifdef FIFO_DRAIN_STATS_EN
  ,
  output logic [cnt_w-1:0] n_fwd,
  output logic [cnt_w-1:0] n_drop
`endif
);

  drain_state_t state, state_nx;
  logic [1:0]   count;
  logic         xfer;
  logic         enter;
  logic         wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    fifo_pop = 1'b0;
    unique case (state)
      ST_RUN: begin
        fifo_pop = fifo_pndng & en & (count < 2'(SKID_DEPTH));
        if (flush) state_nx = ST_FLUSH;
      end
      ST_FLUSH: begin
        fifo_pop = fifo_pndng;
        if (!flush && !fifo_pndng) state_nx = ST_RUN;
      end
      default: ;
    endcase
    if (rst) fifo_pop = 1'b0;
  end

  assign out_valid = (count != 2'd0) && (state == ST_RUN);
  assign xfer      = out_valid & out_ready;
  assign enter     = (state == ST_RUN) & flush;
  assign wr        = fifo_pop & (state == ST_RUN);
  assign busy      = (count != 2'd0) || (state == ST_FLUSH);

  fifo_drain_skid #(
    .width(width)
  ) u_skid (
    .clk  (clk),
    .rst  (rst),
    .clr  (enter),
    .wr   (wr),
    .rd   (xfer),
    .din  (fifo_dout),
    .dout (dato_out),
    .count(count)
  );

`ifdef FIFO_DRAIN_STATS_EN
  logic [1:0]     drop_amt;
  logic [cnt_w:0] drop_sum;

  // on flush entry everything that would have remained buffered is lost
  always_comb begin
    drop_amt = 2'd0;
    if (enter)
      drop_amt = count + 2'(wr) - 2'(xfer);
    else if (state == ST_FLUSH)
      drop_amt = 2'(fifo_pop);
  end

  assign drop_sum = {1'b0, n_drop} + (cnt_w+1)'(drop_amt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_fwd  <= '0;
      n_drop <= '0;
    end else begin
      if (xfer && (n_fwd != '1)) n_fwd <= n_fwd + 1'b1;
      if (drop_sum[cnt_w]) n_drop <= '1;
      else                 n_drop <= drop_sum[cnt_w-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_fifo_drain.sv
// Directed and randomized bench for fifo_drain with a behavioural FWFT FIFO upstream.
module tb_fifo_drain;

  localparam int W  = 16;
  localparam int CW = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] fifo_dout;
  logic         fifo_pndng;
  logic         fifo_pop;
  logic         en;
  logic         flush;
  logic [W-1:0] dato_out;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
`ifdef FIFO_DRAIN_STATS_EN
  logic [CW-1:0] n_fwd;
  logic [CW-1:0] n_drop;
`endif

  always #5 clk = ~clk;

  logic [W-1:0] mem [0:255];
  logic [7:0]   wrp = 8'd0;
  logic [7:0]   rdp = 8'd0;
  logic         push_req = 1'b0;
  logic         fifo_clr = 1'b0;
  logic [W-1:0] push_data = '0;

  assign fifo_dout  = mem[rdp];
  assign fifo_pndng = (wrp != rdp);

  always @(posedge clk) begin
    if (fifo_clr)      rdp <= wrp;
    else if (fifo_pop) rdp <= rdp + 8'd1;
    if (push_req) begin
      mem[wrp] <= push_data;
      wrp      <= wrp + 8'd1;
    end
  end

  int           pop_cnt = 0;
  logic [W-1:0] rx_q[$];
  int           occ = 0;
  int           max_occ = 0;
  logic         occ_clr = 1'b0;

  always @(posedge clk) begin
    if (fifo_pop) pop_cnt <= pop_cnt + 1;
    if (out_valid && out_ready) rx_q.push_back(dato_out);
    if (occ_clr) begin
      occ     <= 0;
      max_occ <= 0;
    end else begin
      occ <= occ + int'(fifo_pop) - int'(out_valid && out_ready);
      if (occ > max_occ) max_occ <= occ;
    end
  end

  fifo_drain #(
    .width(W),
    .cnt_w(CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_dout (fifo_dout),
    .fifo_pndng(fifo_pndng),
    .fifo_pop  (fifo_pop),
    .en        (en),
    .flush     (flush),
    .dato_out  (dato_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
`ifdef FIFO_DRAIN_STATS_EN
    ,
    .n_fwd     (n_fwd),
    .n_drop    (n_drop)
`endif
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] d);
    push_req  = 1'b1;
    push_data = d;
    cyc(1);
    push_req  = 1'b0;
  endtask

  initial begin
    int           base_rx;
    int           base_pop;
    int           errs;
    logic [7:0]   lvl;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] d;
`ifdef FIFO_DRAIN_STATS_EN
    logic [CW-1:0] fwd0, drop0;
`endif

    rst       = 1'b1;
    en        = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    cyc(1);
    push(16'hBEEF);
    cyc(2);
    chk("rst_pndng", fifo_pndng, 1'b1);
    chk("rst_pop", fifo_pop, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_dato", dato_out, 16'h0);
    en       = 1'b0;
    fifo_clr = 1'b1;
    cyc(1);
    fifo_clr = 1'b0;
    rst      = 1'b0;
    cyc(1);

    // stream
    out_ready = 1'b1;
    base_rx   = rx_q.size();
    for (int i = 1; i <= 8; i++) push(16'(i));
    en = 1'b1;
    #1;
    chk("t2_first_pop", fifo_pop, 1'b1);
    chk("t2_lat_valid0", out_valid, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      cyc(1);
      chk("t2_valid", out_valid, 1'b1);
      chk("t2_dato", dato_out, 16'(i));
    end
    cyc(1);
    chk("t2_done_valid", out_valid, 1'b0);
    chk("t2_rx_cnt", rx_q.size() - base_rx, 8);
    errs = 0;
    for (int k = 0; k < 8; k++)
      if (base_rx + k < rx_q.size() && rx_q[base_rx+k] !== 16'(k+1)) errs++;
    chk("t2_order", errs, 0);

    // backpressure
    out_ready = 1'b0;
    en        = 1'b0;
    base_pop  = pop_cnt;
    for (int i = 1; i <= 5; i++) push(16'(i));
    en = 1'b1;
    cyc(6);
    chk("t3_pops", pop_cnt - base_pop, 2);
    chk("t3_pop_blk", fifo_pop, 1'b0);
    chk("t3_valid", out_valid, 1'b1);
    chk("t3_dato", dato_out, 16'h0001);
    out_ready = 1'b0;
    cyc(3);
    chk("t3_dato_hold", dato_out, 16'h0001);
    base_rx   = rx_q.size();
    out_ready = 1'b1;
    cyc(8);
    chk("t3_rx_cnt", rx_q.size() - base_rx, 5);
    errs = 0;
    for (int k = 0; k < 5; k++)
      if (base_rx + k < rx_q.size() && rx_q[base_rx+k] !== 16'(k+1)) errs++;
    chk("t3_order", errs, 0);
    chk("t3_idle", out_valid, 1'b0);

    // flush
    out_ready = 1'b0;
`ifdef FIFO_DRAIN_STATS_EN
    fwd0  = n_fwd;
    drop0 = n_drop;
`endif
    for (int i = 0; i < 6; i++) push(16'h0021 + 16'(i));
    cyc(2);
    chk("t4_pre_pop", fifo_pop, 1'b0);
    chk("t4_pre_valid", out_valid, 1'b1);
    chk("t4_pre_dato", dato_out, 16'h0021);
    base_rx = rx_q.size();
    flush   = 1'b1;
    cyc(1);
    flush = 1'b0;
    chk("t4_fl_valid", out_valid, 1'b0);
    chk("t4_fl_busy", busy, 1'b1);
    cyc(8);
    chk("t4_pndng", fifo_pndng, 1'b0);
    chk("t4_busy", busy, 1'b0);
    chk("t4_valid", out_valid, 1'b0);
    chk("t4_rx_none", rx_q.size() - base_rx, 0);
`ifdef FIFO_DRAIN_STATS_EN
    chk("t4_n_drop", n_drop - drop0, 6);
    chk("t4_n_fwd", n_fwd - fwd0, 0);
`endif

    // enable gating
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(16'h0031 + 16'(i));
    cyc(2);
    en        = 1'b0;
    out_ready = 1'b1;
    base_rx   = rx_q.size();
    cyc(4);
    chk("t5_rx2", rx_q.size() - base_rx, 2);
    chk("t5_no_pop", fifo_pop, 1'b0);
    chk("t5_pndng", fifo_pndng, 1'b1);
    chk("t5_valid", out_valid, 1'b0);
    errs = 0;
    for (int k = 0; k < 2; k++)
      if (base_rx + k < rx_q.size() && rx_q[base_rx+k] !== 16'h0031 + 16'(k)) errs++;
    chk("t5_order", errs, 0);
    en = 1'b1;
    #1;
    chk("t5_resume", fifo_pop, 1'b1);
    cyc(2);
    chk("t5_rx3", rx_q.size() - base_rx, 3);
    if (rx_q.size() > 0) chk("t5_last", rx_q[rx_q.size()-1], 16'h0033);

    // random mix
    occ_clr = 1'b1;
    cyc(1);
    occ_clr = 1'b0;
    base_rx = rx_q.size();
    for (int c = 0; c < 10000; c++) begin
      lvl = wrp - rdp;
      if (lvl < 8'd6 && $urandom_range(0, 1) == 1) begin
        d         = W'($urandom);
        push_req  = 1'b1;
        push_data = d;
        exp_q.push_back(d);
      end else begin
        push_req = 1'b0;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      cyc(1);
    end
    push_req  = 1'b0;
    out_ready = 1'b1;
    cyc(30);
    chk("t6_rx_cnt", rx_q.size() - base_rx, exp_q.size());
    errs = 0;
    for (int k = 0; k < exp_q.size(); k++)
      if (base_rx + k < rx_q.size() && rx_q[base_rx+k] !== exp_q[k]) errs++;
    chk("t6_order", errs, 0);
    chk("t6_max_occ_le2", (max_occ <= 2), 1'b1);
    chk("t6_idle", busy, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
